// File: rtl/pcie_datalink_pkg.sv
// Shared data-link-layer types: link status, DLLP arbiter state and source indices.
package pcie_datalink_pkg;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_INIT     = 2'd1,
    DL_ACTIVE   = 2'd2
  } pcie_dl_status_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } dllp_arb_state_e;

  localparam int DllpSrcAckNak = 0;
  localparam int DllpSrcFc     = 1;
  localparam int DllpSrcPm     = 2;

  // A DLLP is always a 4-byte body beat followed by a CRC beat carrying tlast.
  localparam int DllpBeats = 2;

endpackage

// File: rtl/dllp_prio_picker.sv
// Combinational fixed-priority picker: one-hot grant of the lowest-index request.
module dllp_prio_picker
  import pcie_datalink_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic               any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/dllp_tx_arbiter.sv
// Packet-atomic DLLP transmit arbiter: fixed priority with starvation promotion,
// plus a flush mode that drains a half-sent DLLP when the link drops.
module dllp_tx_arbiter
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 3,
  parameter int NUM_SRC      = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  pcie_dl_status_e                     link_status_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_SRC-1:0][KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                  s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                  s_axis_tlast,
  input  logic [NUM_SRC-1:0][USER_WIDTH-1:0]  s_axis_tuser,
  output logic [NUM_SRC-1:0]                  s_axis_tready,
  output logic [DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]               m_axis_tkeep,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic [USER_WIDTH-1:0]               m_axis_tuser,
  input  logic                                m_axis_tready,
  output logic [NUM_SRC-1:0]                  grant_o,
  output logic [NUM_SRC-1:0]                  starve_o
);

  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  dllp_arb_state_e                  state_q;
  logic [NUM_SRC-1:0]               grant_q;
  logic [NUM_SRC-1:0][CntW-1:0]     cnt_q;

  logic [NUM_SRC-1:0] starve_vec;
  logic [NUM_SRC-1:0] valid_starved;
  logic [NUM_SRC-1:0] win_starved;
  logic [NUM_SRC-1:0] win_plain;
  logic [NUM_SRC-1:0] winner_d;
  logic               any_starved;
  logic               any_plain;
  logic               link_up;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  m_fire;

  assign link_up = (link_status_i != DL_INACTIVE);

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      starve_vec[i] = (cnt_q[i] == CntMax);
    end
  end

  assign valid_starved = s_axis_tvalid & starve_vec;
  assign starve_o      = starve_vec;

  dllp_prio_picker #(.NUM_SRC(NUM_SRC)) u_pick_starved (
    .req_i (valid_starved),
    .gnt_o (win_starved),
    .any_o (any_starved)
  );

  dllp_prio_picker #(.NUM_SRC(NUM_SRC)) u_pick_plain (
    .req_i (s_axis_tvalid),
    .gnt_o (win_plain),
    .any_o (any_plain)
  );

  // A promoted source outranks every non-promoted one, whatever its index.
  assign winner_d = any_starved ? win_starved : win_plain;

  // grant_q is one-hot or zero, so an OR of masked lanes is the mux.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        sel_data  = sel_data | s_axis_tdata[i];
        sel_keep  = sel_keep | s_axis_tkeep[i];
        sel_user  = sel_user | s_axis_tuser[i];
        sel_valid = sel_valid | s_axis_tvalid[i];
        sel_last  = sel_last | s_axis_tlast[i];
      end
    end
  end

  assign m_axis_tdata  = sel_data;
  assign m_axis_tkeep  = sel_keep;
  assign m_axis_tuser  = sel_user;
  assign m_axis_tlast  = sel_last;
  assign m_axis_tvalid = (state_q == ST_BUSY) && sel_valid;
  assign m_fire        = m_axis_tvalid && m_axis_tready;
  assign grant_o       = grant_q;

  always_comb begin
    s_axis_tready = '0;
    case (state_q)
      ST_BUSY:  s_axis_tready = grant_q & {NUM_SRC{m_axis_tready}};
      ST_FLUSH: s_axis_tready = grant_q;
      default:  s_axis_tready = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (link_up && any_plain) begin
            grant_q <= winner_d;
            state_q <= ST_BUSY;
            for (int i = 0; i < NUM_SRC; i++) begin
              if (winner_d[i]) begin
                cnt_q[i] <= '0;
              end else if (s_axis_tvalid[i] && (cnt_q[i] != CntMax)) begin
                cnt_q[i] <= cnt_q[i] + CntOne;
              end
            end
          end
        end
        ST_BUSY: begin
          if (m_fire && sel_last) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else if (!link_up && !m_fire) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Owner's remaining beats are swallowed until its tlast goes by.
          if (sel_valid && sel_last) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(grant_q));

  a_owner_when_active: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q != ST_IDLE) |-> (grant_q != '0));

endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// Directed bench for dllp_tx_arbiter with hand-computed expected beats and grants.
module tb_dllp_tx_arbiter;
  import pcie_datalink_pkg::*;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 3;
  localparam int NS = 3;

  logic                  clk;
  logic                  rst;
  pcie_dl_status_e       link;
  logic [NS-1:0][DW-1:0] s_tdata;
  logic [NS-1:0][KW-1:0] s_tkeep;
  logic [NS-1:0]         s_tvalid;
  logic [NS-1:0]         s_tlast;
  logic [NS-1:0][UW-1:0] s_tuser;
  logic [NS-1:0]         s_tready;
  logic [DW-1:0]         m_tdata;
  logic [KW-1:0]         m_tkeep;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic [UW-1:0]         m_tuser;
  logic                  m_tready;
  logic [NS-1:0]         grant;
  logic [NS-1:0]         starve;

  dllp_tx_arbiter #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .NUM_SRC(NS), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .link_status_i(link),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .grant_o(grant), .starve_o(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source models: per-source beat buffers presented in order until accepted.
  logic [DW-1:0] sbuf_d [NS][16];
  logic          sbuf_l [NS][16];
  int            head [NS];
  int            tail [NS];

  // Accepted output beats.
  logic [DW-1:0] log_d [64];
  logic          log_l [64];
  logic [NS-1:0] log_g [64];
  int            nlog = 0;

  logic          smp_mvalid, smp_mlast;
  logic [DW-1:0] smp_mdata;
  logic [KW-1:0] smp_mkeep;
  logic [UW-1:0] smp_muser;
  logic [NS-1:0] smp_grant, smp_starve, smp_sready;

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_tkeep[i] = 4'hF;
      s_tuser[i] = UW'(i);
      if (head[i] < tail[i]) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = sbuf_d[i][head[i]];
        s_tlast[i]  = sbuf_l[i][head[i]];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i]  = '0;
        s_tlast[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    if (head[s] == tail[s]) begin
      head[s] = 0;
      tail[s] = 0;
    end
    sbuf_d[s][tail[s]] = d0; sbuf_l[s][tail[s]] = 1'b0; tail[s]++;
    sbuf_d[s][tail[s]] = d1; sbuf_l[s][tail[s]] = 1'b1; tail[s]++;
    drive();
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
  endtask

  // One clock: sample at negedge, then advance sources just after posedge.
  task automatic step();
    logic [NS-1:0] hs;
    @(negedge clk);
    smp_mvalid = m_tvalid; smp_mlast = m_tlast; smp_mdata = m_tdata;
    smp_mkeep  = m_tkeep;  smp_muser = m_tuser;
    smp_grant  = grant;    smp_starve = starve; smp_sready = s_tready;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready && nlog < 64) begin
      log_d[nlog] = m_tdata; log_l[nlog] = m_tlast; log_g[nlog] = grant;
      nlog++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (hs[i]) head[i]++;
    drive();
  endtask

  initial begin
    int base;
    int first1;
    logic [NS-1:0] prev_starve, st_at_win, st_before_win;

    rst = 1'b1;
    link = DL_ACTIVE;
    m_tready = 1'b1;
    clear_srcs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_mvalid", 64'(m_tvalid), 64'(0));
    chk("rst_sready", 64'(s_tready), 64'(0));
    chk("rst_starve", 64'(starve), 64'(0));
    rst = 1'b0;

    // Single DLLP from src1.
    push(1, 32'h0800_0123, 32'h0000_5A5A);
    step();
    chk("t1_c0_mvalid", 64'(smp_mvalid), 64'(0));
    chk("t1_c0_grant", 64'(smp_grant), 64'(0));
    step();
    chk("t1_c1_grant", 64'(smp_grant), 64'(3'b010));
    chk("t1_c1_mvalid", 64'(smp_mvalid), 64'(1));
    chk("t1_c1_data", 64'(smp_mdata), 64'(32'h0800_0123));
    chk("t1_c1_last", 64'(smp_mlast), 64'(0));
    chk("t1_c1_user", 64'(smp_muser), 64'(1));
    chk("t1_c1_keep", 64'(smp_mkeep), 64'(4'hF));
    chk("t1_c1_sready", 64'(smp_sready), 64'(3'b010));
    step();
    chk("t1_c2_data", 64'(smp_mdata), 64'(32'h0000_5A5A));
    chk("t1_c2_last", 64'(smp_mlast), 64'(1));
    step();
    chk("t1_c3_grant", 64'(smp_grant), 64'(0));
    chk("t1_c3_mvalid", 64'(smp_mvalid), 64'(0));

    // Src0 and src1 together: src0 first, packets not interleaved.
    base = nlog;
    push(0, 32'hA000_0001, 32'h0000_A2A2);
    push(1, 32'hB000_0001, 32'h0000_B2B2);
    repeat (8) step();
    chk("t2_nbeats", 64'(nlog - base), 64'(4));
    chk("t2_b0", 64'({log_g[base], log_l[base], log_d[base]}), 64'({3'b001, 1'b0, 32'hA000_0001}));
    chk("t2_b1", 64'({log_g[base+1], log_l[base+1], log_d[base+1]}), 64'({3'b001, 1'b1, 32'h0000_A2A2}));
    chk("t2_b2", 64'({log_g[base+2], log_l[base+2], log_d[base+2]}), 64'({3'b010, 1'b0, 32'hB000_0001}));
    chk("t2_b3", 64'({log_g[base+3], log_l[base+3], log_d[base+3]}), 64'({3'b010, 1'b1, 32'h0000_B2B2}));

    // Starvation: src0 saturating, src1 promoted after losing 4 times.
    base = nlog;
    for (int k = 0; k < 6; k++) push(0, 32'h1000_0000 + k, 32'h0000_1100 + k);
    push(1, 32'h2000_0001, 32'h0000_2222);
    first1 = -1;
    prev_starve = '0;
    st_at_win = '0;
    st_before_win = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (first1 < 0 && smp_grant == 3'b010) begin
        first1 = c;
        st_at_win = smp_starve;
        st_before_win = prev_starve;
      end
      prev_starve = smp_starve;
    end
    chk("t3_src1_won", 64'(first1 >= 0), 64'(1));
    chk("t3_nbeats", 64'(nlog - base), 64'(14));
    chk("t3_b8_src1", 64'({log_g[base+8], log_d[base+8]}), 64'({3'b010, 32'h2000_0001}));
    chk("t3_b7_src0", 64'({log_g[base+7], log_d[base+7]}), 64'({3'b001, 32'h0000_1103}));
    chk("t3_starve_before", 64'(st_before_win), 64'(3'b010));
    chk("t3_starve_after", 64'(st_at_win), 64'(0));
    chk("t3_starve_end", 64'(smp_starve), 64'(0));

    // Downstream backpressure mid-packet.
    base = nlog;
    push(2, 32'hC000_0001, 32'h0000_C2C2);
    step();
    step();
    m_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_hold", 64'({smp_mvalid, smp_sready, smp_mdata}), 64'({1'b1, 3'b000, 32'h0000_C2C2}));
    end
    m_tready = 1'b1;
    step();
    step();
    chk("t4_nbeats", 64'(nlog - base), 64'(2));
    chk("t4_b0", 64'({log_g[base], log_l[base], log_d[base]}), 64'({3'b100, 1'b0, 32'hC000_0001}));
    chk("t4_b1", 64'({log_g[base+1], log_l[base+1], log_d[base+1]}), 64'({3'b100, 1'b1, 32'h0000_C2C2}));

    // Link drops after beat 1: rest of the DLLP is flushed, no grants while down.
    base = nlog;
    push(0, 32'hD000_0001, 32'h0000_D2D2);
    step();
    step();
    link = DL_INACTIVE;
    m_tready = 1'b0;
    step();
    step();
    chk("t5_flush_mvalid", 64'(smp_mvalid), 64'(0));
    chk("t5_flush_sready", 64'(smp_sready), 64'(3'b001));
    chk("t5_consumed", 64'(tail[0] - head[0]), 64'(0));
    m_tready = 1'b1;
    push(1, 32'hE000_0001, 32'h0000_E2E2);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t5_idle_down", 64'({smp_grant, smp_sready}), 64'(0));
    end
    chk("t5_nbeats_down", 64'(nlog - base), 64'(1));
    link = DL_ACTIVE;
    repeat (4) step();
    chk("t5_nbeats_up", 64'(nlog - base), 64'(3));
    chk("t5_after_up", 64'({log_g[base+1], log_d[base+1]}), 64'({3'b010, 32'hE000_0001}));

    // Asynchronous reset mid-packet.
    push(0, 32'hF000_0001, 32'h0000_F2F2);
    push(1, 32'hF100_0001, 32'h0000_F1F1);
    step();
    step();
    chk("t6_pre_cnt1", 64'(dut.cnt_q[1]), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_mvalid", 64'(m_tvalid), 64'(0));
    chk("t6_grant", 64'(grant), 64'(0));
    chk("t6_sready", 64'(s_tready), 64'(0));
    chk("t6_cnt", 64'(dut.cnt_q), 64'(0));
    clear_srcs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = nlog;
    push(2, 32'h3000_0001, 32'h0000_3333);
    repeat (4) step();
    chk("t6_recover", 64'({log_g[base+1], log_l[base+1], log_d[base+1]}), 64'({3'b100, 1'b1, 32'h0000_3333}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
